// File: rtl/axi4_lite_slave_regfile_if.sv
// AXI4-Lite bus bundle between a master and the register-file slave.
// Signal names follow the slave's point of view.
interface axi4_lite_slave_regfile_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr_slave_input;
    logic [2:0]          awprot_slave_input;
    logic                awvalid_slave_input;
    logic                awready_slave_output;
    logic [DATA_W-1:0]   wdata_slave_input;
    logic [DATA_W/8-1:0] wstrb_slave_input;
    logic                wvalid_slave_input;
    logic                wready_slave_output;
    logic [1:0]          bresp_slave_output;
    logic                bvalid_slave_output;
    logic                bready_slave_input;
    logic [ADDR_W-1:0]   araddr_slave_input;
    logic [2:0]          arprot_slave_input;
    logic                arvalid_slave_input;
    logic                arready_slave_output;
    logic [DATA_W-1:0]   rdata_slave_output;
    logic [1:0]          rresp_slave_output;
    logic                rvalid_slave_output;
    logic                rready_slave_input;

    modport slave (
        input  awaddr_slave_input, awprot_slave_input,
        input  awvalid_slave_input,
        output awready_slave_output,
        input  wdata_slave_input, wstrb_slave_input,
        input  wvalid_slave_input,
        output wready_slave_output,
        output bresp_slave_output, bvalid_slave_output,
        input  bready_slave_input,
        input  araddr_slave_input, arprot_slave_input,
        input  arvalid_slave_input,
        output arready_slave_output,
        output rdata_slave_output, rresp_slave_output,
        output rvalid_slave_output,
        input  rready_slave_input
    );

    modport master (
        output awaddr_slave_input, awprot_slave_input,
        output awvalid_slave_input,
        input  awready_slave_output,
        output wdata_slave_input, wstrb_slave_input,
        output wvalid_slave_input,
        input  wready_slave_output,
        input  bresp_slave_output, bvalid_slave_output,
        output bready_slave_input,
        output araddr_slave_input, arprot_slave_input,
        output arvalid_slave_input,
        input  arready_slave_output,
        input  rdata_slave_output, rresp_slave_output,
        input  rvalid_slave_output,
        output rready_slave_input
    );
endinterface

// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite slave with a byte-strobed register file.
// Define AXIL_SLAVE_PROT_CHECK_EN to reject unprivileged accesses.
module axi4_lite_slave_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 12,
    parameter int NUM_REGS = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    axi4_lite_slave_regfile_if.slave   bus,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat_output
);
    localparam int STRB_W = DATA_W / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_W - LSB;
    localparam logic [IDX_W:0] NREGS = (IDX_W+1)'(NUM_REGS);

    typedef enum logic { WR_IDLE, WR_RESP } wr_state_e;
    typedef enum logic { RD_IDLE, RD_DATA } rd_state_e;

    wr_state_e wr_state_q, wr_state_d;
    rd_state_e rd_state_q, rd_state_d;
    logic en_q;
    logic aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [ADDR_W-1:0] awaddr_q;
    logic [2:0]        awprot_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic [1:0]        bresp_q, rresp_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    logic awready, wready, bvalid, arready, rvalid;
    logic aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_W-1:0] aw_addr;
    logic [2:0]        aw_prot;
    logic [DATA_W-1:0] w_data;
    logic [STRB_W-1:0] w_strb;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic wr_err, rd_err;
    logic [DATA_W-1:0] rd_val;
    logic unused_bits;

    // Channel data comes from the holding register once captured
    assign aw_addr = aw_held_q ? awaddr_q : bus.awaddr_slave_input;
    assign aw_prot = aw_held_q ? awprot_q : bus.awprot_slave_input;
    assign w_data  = w_held_q  ? wdata_q  : bus.wdata_slave_input;
    assign w_strb  = w_held_q  ? wstrb_q  : bus.wstrb_slave_input;

    assign wr_idx = aw_addr[ADDR_W-1:LSB];
    assign rd_idx = bus.araddr_slave_input[ADDR_W-1:LSB];

`ifdef AXIL_SLAVE_PROT_CHECK_EN
    assign wr_err = ({1'b0, wr_idx} >= NREGS) || !aw_prot[0];
    assign rd_err = ({1'b0, rd_idx} >= NREGS)
                 || !bus.arprot_slave_input[0];
`else
    assign wr_err = ({1'b0, wr_idx} >= NREGS);
    assign rd_err = ({1'b0, rd_idx} >= NREGS);
`endif

    assign unused_bits = ^{aw_prot, bus.arprot_slave_input,
                           aw_addr[LSB-1:0],
                           bus.araddr_slave_input[LSB-1:0]};

    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awready    = 1'b0;
        wready     = 1'b0;
        bvalid     = 1'b0;
        aw_hs      = 1'b0;
        w_hs       = 1'b0;
        commit     = 1'b0;
        unique case (wr_state_q)
            WR_IDLE: begin
                awready   = en_q && !aw_held_q;
                wready    = en_q && !w_held_q;
                aw_hs     = awready && bus.awvalid_slave_input;
                w_hs      = wready && bus.wvalid_slave_input;
                aw_held_d = aw_held_q | aw_hs;
                w_held_d  = w_held_q | w_hs;
                commit    = aw_held_d && w_held_d;
                if (commit) wr_state_d = WR_RESP;
            end
            WR_RESP: begin
                bvalid = 1'b1;
                if (bus.bready_slave_input) begin
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    wr_state_d = WR_IDLE;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        arready    = 1'b0;
        rvalid     = 1'b0;
        ar_hs      = 1'b0;
        unique case (rd_state_q)
            RD_IDLE: begin
                arready = en_q;
                ar_hs   = arready && bus.arvalid_slave_input;
                if (ar_hs) rd_state_d = RD_DATA;
            end
            RD_DATA: begin
                rvalid = 1'b1;
                if (bus.rready_slave_input) rd_state_d = RD_IDLE;
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (rd_idx == IDX_W'(i)) rd_val = regs_q[i];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_state_q <= WR_IDLE;
            rd_state_q <= RD_IDLE;
            en_q       <= 1'b0;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            awprot_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= 2'b00;
            rresp_q    <= 2'b00;
            rdata_q    <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            en_q       <= 1'b1;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            if (aw_hs) begin
                awaddr_q <= bus.awaddr_slave_input;
                awprot_q <= bus.awprot_slave_input;
            end
            if (w_hs) begin
                wdata_q <= bus.wdata_slave_input;
                wstrb_q <= bus.wstrb_slave_input;
            end
            if (commit) begin
                bresp_q <= wr_err ? 2'b10 : 2'b00;
                for (int i = 0; i < NUM_REGS; i++)
                    for (int b = 0; b < STRB_W; b++)
                        if (!wr_err && wr_idx == IDX_W'(i) && w_strb[b])
                            regs_q[i][b*8 +: 8] <= w_data[b*8 +: 8];
            end
            // Array read sees pre-commit contents on a same-edge write
            if (ar_hs) begin
                rdata_q <= rd_err ? '0 : rd_val;
                rresp_q <= rd_err ? 2'b10 : 2'b00;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
        assign regs_flat_output[gi*DATA_W +: DATA_W] = regs_q[gi];
    end

    assign bus.awready_slave_output = awready;
    assign bus.wready_slave_output  = wready;
    assign bus.bvalid_slave_output  = bvalid;
    assign bus.bresp_slave_output   = bresp_q;
    assign bus.arready_slave_output = arready;
    assign bus.rvalid_slave_output  = rvalid;
    assign bus.rdata_slave_output   = rdata_q;
    assign bus.rresp_slave_output   = rresp_q;
endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Scoreboard bench for the AXI4-Lite register-file slave.
module tb_axi4_lite_slave_regfile;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 12;
    localparam int NUM_REGS = 16;
    localparam int TMO      = 50;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    axi4_lite_slave_regfile_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();
    logic [NUM_REGS*DATA_W-1:0] regs_flat;

    axi4_lite_slave_regfile #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .regs_flat_output(regs_flat)
    );

    int checks = 0;
    int errors = 0;
    logic [1:0]  bq[$];
    logic [33:0] rq[$];
    logic [31:0] model [NUM_REGS];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    function automatic logic [1:0] exp_resp(input logic [11:0] a,
                                            input logic [2:0] p);
        logic e;
        e = (int'(a[11:2]) >= NUM_REGS);
`ifdef AXIL_SLAVE_PROT_CHECK_EN
        e = e || !p[0];
`else
        if (p === 3'bxxx) e = 1'b1;
`endif
        return e ? 2'b10 : 2'b00;
    endfunction

    task automatic push_write(input logic [11:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [2:0] p);
        logic [1:0] r;
        r = exp_resp(a, p);
        bq.push_back(r);
        if (r == 2'b00)
            for (int b = 0; b < 4; b++)
                if (s[b]) model[int'(a[11:2])][b*8 +: 8] = d[b*8 +: 8];
    endtask

    task automatic push_read(input logic [11:0] a, input logic [2:0] p);
        logic [1:0] r;
        logic [31:0] d;
        r = exp_resp(a, p);
        d = 32'h0;
        if (r == 2'b00) d = model[int'(a[11:2])];
        rq.push_back({d, r});
    endtask

    task automatic aw_send(input logic [11:0] a, input logic [2:0] p);
        int n = 0;
        @(negedge clk);
        bus.awaddr_slave_input  = a;
        bus.awprot_slave_input  = p;
        bus.awvalid_slave_input = 1'b1;
        while (bus.awready_slave_output !== 1'b1 && n < TMO) begin
            @(negedge clk); n++;
        end
        checks++;
        if (n >= TMO) begin
            errors++;
            $display("FAIL aw_wait: got %0d cycles want < %0d", n, TMO);
        end
        @(posedge clk);
        @(negedge clk);
        bus.awvalid_slave_input = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        @(negedge clk);
        bus.wdata_slave_input  = d;
        bus.wstrb_slave_input  = s;
        bus.wvalid_slave_input = 1'b1;
        while (bus.wready_slave_output !== 1'b1 && n < TMO) begin
            @(negedge clk); n++;
        end
        checks++;
        if (n >= TMO) begin
            errors++;
            $display("FAIL w_wait: got %0d cycles want < %0d", n, TMO);
        end
        @(posedge clk);
        @(negedge clk);
        bus.wvalid_slave_input = 1'b0;
    endtask

    task automatic ar_send(input logic [11:0] a, input logic [2:0] p);
        int n = 0;
        @(negedge clk);
        bus.araddr_slave_input  = a;
        bus.arprot_slave_input  = p;
        bus.arvalid_slave_input = 1'b1;
        while (bus.arready_slave_output !== 1'b1 && n < TMO) begin
            @(negedge clk); n++;
        end
        checks++;
        if (n >= TMO) begin
            errors++;
            $display("FAIL ar_wait: got %0d cycles want < %0d", n, TMO);
        end
        @(posedge clk);
        @(negedge clk);
        bus.arvalid_slave_input = 1'b0;
    endtask

    task automatic b_recv(input int stall);
        int n = 0;
        logic [1:0] exp;
        bus.bready_slave_input = 1'b0;
        while (bus.bvalid_slave_output !== 1'b1 && n < TMO) begin
            @(negedge clk); n++;
        end
        exp = 2'b00;
        if (bq.size() > 0) exp = bq.pop_front();
        checks++;
        if (n >= TMO) begin
            errors++;
            $display("FAIL b_wait: got %0d cycles want < %0d", n, TMO);
        end else if (bus.bresp_slave_output !== exp) begin
            errors++;
            $display("FAIL bresp: got %b want %b",
                     bus.bresp_slave_output, exp);
        end
        repeat (stall) begin
            @(negedge clk);
            checks++;
            if (bus.bvalid_slave_output !== 1'b1 ||
                bus.awready_slave_output !== 1'b0 ||
                bus.wready_slave_output !== 1'b0 ||
                bus.bresp_slave_output !== exp) begin
                errors++;
                $display("FAIL b_stall: got v%b aw%b w%b r%b want v1 aw0 w0 r%b",
                         bus.bvalid_slave_output, bus.awready_slave_output,
                         bus.wready_slave_output, bus.bresp_slave_output, exp);
            end
        end
        bus.bready_slave_input = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.bready_slave_input = 1'b0;
        checks++;
        if (bus.bvalid_slave_output !== 1'b0 ||
            bus.awready_slave_output !== 1'b1 ||
            bus.wready_slave_output !== 1'b1) begin
            errors++;
            $display("FAIL b_after: got v%b aw%b w%b want v0 aw1 w1",
                     bus.bvalid_slave_output, bus.awready_slave_output,
                     bus.wready_slave_output);
        end
    endtask

    task automatic r_recv(input int stall);
        int n = 0;
        logic [33:0] exp;
        logic [33:0] got;
        bus.rready_slave_input = 1'b0;
        while (bus.rvalid_slave_output !== 1'b1 && n < TMO) begin
            @(negedge clk); n++;
        end
        exp = '0;
        if (rq.size() > 0) exp = rq.pop_front();
        got = {bus.rdata_slave_output, bus.rresp_slave_output};
        checks++;
        if (n >= TMO) begin
            errors++;
            $display("FAIL r_wait: got %0d cycles want < %0d", n, TMO);
        end else if (got !== exp) begin
            errors++;
            $display("FAIL rdata: got %h/%b want %h/%b",
                     got[33:2], got[1:0], exp[33:2], exp[1:0]);
        end
        repeat (stall) begin
            @(negedge clk);
            got = {bus.rdata_slave_output, bus.rresp_slave_output};
            checks++;
            if (bus.rvalid_slave_output !== 1'b1 ||
                bus.arready_slave_output !== 1'b0 || got !== exp) begin
                errors++;
                $display("FAIL r_stall: got v%b ar%b %h want v1 ar0 %h",
                         bus.rvalid_slave_output, bus.arready_slave_output,
                         got, exp);
            end
        end
        bus.rready_slave_input = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rready_slave_input = 1'b0;
        checks++;
        if (bus.rvalid_slave_output !== 1'b0 ||
            bus.arready_slave_output !== 1'b1) begin
            errors++;
            $display("FAIL r_after: got v%b ar%b want v0 ar1",
                     bus.rvalid_slave_output, bus.arready_slave_output);
        end
    endtask

    task automatic check_regs(input string name);
        logic [NUM_REGS*DATA_W-1:0] e;
        for (int i = 0; i < NUM_REGS; i++) e[i*32 +: 32] = model[i];
        checks++;
        if (regs_flat !== e) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, regs_flat, e);
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] p);
        push_write(a, d, s, p);
        fork
            aw_send(a, p);
            w_send(d, s);
        join
        checks++;
        if (bus.bvalid_slave_output !== 1'b1) begin
            errors++;
            $display("FAIL b_latency: got %b want 1",
                     bus.bvalid_slave_output);
        end
        check_regs("regs_at_b");
        b_recv(0);
    endtask

    task automatic rd(input logic [11:0] a, input logic [2:0] p);
        push_read(a, p);
        ar_send(a, p);
        checks++;
        if (bus.rvalid_slave_output !== 1'b1) begin
            errors++;
            $display("FAIL r_latency: got %b want 1",
                     bus.rvalid_slave_output);
        end
        r_recv(0);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.awready_slave_output, bus.wready_slave_output,
             bus.arready_slave_output, bus.bvalid_slave_output,
             bus.rvalid_slave_output} !== 5'b0 ||
            bus.bresp_slave_output !== 2'b00 ||
            bus.rresp_slave_output !== 2'b00 ||
            bus.rdata_slave_output !== 32'h0) begin
            errors++;
            $display("FAIL reset_out: got rdy %b%b%b v %b%b want 00000",
                     bus.awready_slave_output, bus.wready_slave_output,
                     bus.arready_slave_output, bus.bvalid_slave_output,
                     bus.rvalid_slave_output);
        end
        check_regs("reset_regs");
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.awready_slave_output, bus.wready_slave_output,
             bus.arready_slave_output} !== 3'b111) begin
            errors++;
            $display("FAIL reset_release: got %b%b%b want 111",
                     bus.awready_slave_output, bus.wready_slave_output,
                     bus.arready_slave_output);
        end
    endtask

    task automatic test_write_read;
        wr(12'h004, 32'hDEADBEEF, 4'hF, 3'b001);
        rd(12'h004, 3'b001);
    endtask

    task automatic test_w_before_aw;
        wr(12'h00C, 32'hAAAAAAAA, 4'hF, 3'b001);
        push_write(12'h00C, 32'h11223344, 4'b0101, 3'b001);
        w_send(32'h11223344, 4'b0101);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.bvalid_slave_output !== 1'b0 ||
            bus.wready_slave_output !== 1'b0 ||
            bus.awready_slave_output !== 1'b1) begin
            errors++;
            $display("FAIL w_first: got v%b w%b aw%b want v0 w0 aw1",
                     bus.bvalid_slave_output, bus.wready_slave_output,
                     bus.awready_slave_output);
        end
        aw_send(12'h00C, 3'b001);
        b_recv(0);
        checks++;
        if (regs_flat[3*32 +: 32] !== 32'hAA22AA44) begin
            errors++;
            $display("FAIL strb_merge: got %h want aa22aa44",
                     regs_flat[3*32 +: 32]);
        end
        check_regs("w_first_regs");
    endtask

    task automatic test_decode_err;
        wr(12'h040, 32'h12345678, 4'hF, 3'b001);
        rd(12'h040, 3'b001);
        wr(12'h018, 32'hFFFFFFFF, 4'h0, 3'b001);
        check_regs("strb_zero");
    endtask

    task automatic test_stall;
        push_write(12'h014, 32'hCAFEF00D, 4'hF, 3'b001);
        fork
            aw_send(12'h014, 3'b001);
            w_send(32'hCAFEF00D, 4'hF);
        join
        b_recv(5);
        push_read(12'h014, 3'b001);
        ar_send(12'h014, 3'b001);
        r_recv(5);
        check_regs("stall_regs");
    endtask

    task automatic test_same_edge;
        wr(12'h008, 32'h5, 4'hF, 3'b001);
        push_read(12'h008, 3'b001);
        push_write(12'h008, 32'h9, 4'hF, 3'b001);
        fork
            aw_send(12'h008, 3'b001);
            w_send(32'h9, 4'hF);
            ar_send(12'h008, 3'b001);
        join
        fork
            b_recv(0);
            r_recv(0);
        join
        rd(12'h008, 3'b001);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++)
            wr(12'(12'h020 + 4*i), $urandom, 4'($urandom_range(0, 15)), 3'b001);
        for (int i = 0; i < 4; i++)
            rd(12'(12'h020 + 4*i), 3'b001);
    endtask

    task automatic test_mid_reset;
        fork
            aw_send(12'h01C, 3'b001);
            w_send(32'h77777777, 4'hF);
        join
        #2 reset = 1'b0;
        #1;
        for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;
        checks++;
        if (bus.bvalid_slave_output !== 1'b0 ||
            bus.awready_slave_output !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got v%b aw%b want v0 aw0",
                     bus.bvalid_slave_output, bus.awready_slave_output);
        end
        check_regs("mid_reset_regs");
        @(negedge clk) reset = 1'b1;
        w_send(32'hBADBAD00, 4'hF);
        #2 reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        push_write(12'h01C, 32'h0000A5A5, 4'hF, 3'b001);
        aw_send(12'h01C, 3'b001);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.bvalid_slave_output !== 1'b0) begin
            errors++;
            $display("FAIL held_cleared: got %b want 0",
                     bus.bvalid_slave_output);
        end
        w_send(32'h0000A5A5, 4'hF);
        b_recv(0);
        check_regs("after_reset_regs");
    endtask

`ifdef AXIL_SLAVE_PROT_CHECK_EN
    task automatic test_prot;
        wr(12'h024, 32'h13572468, 4'hF, 3'b000);
        rd(12'h024, 3'b000);
        wr(12'h024, 32'h13572468, 4'hF, 3'b001);
        rd(12'h024, 3'b001);
    endtask
`endif

    initial begin
        for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;
        bus.awaddr_slave_input  = '0;
        bus.awprot_slave_input  = '0;
        bus.awvalid_slave_input = 1'b0;
        bus.wdata_slave_input   = '0;
        bus.wstrb_slave_input   = '0;
        bus.wvalid_slave_input  = 1'b0;
        bus.bready_slave_input  = 1'b0;
        bus.araddr_slave_input  = '0;
        bus.arprot_slave_input  = '0;
        bus.arvalid_slave_input = 1'b0;
        bus.rready_slave_input  = 1'b0;
        test_reset();
        test_write_read();
        test_w_before_aw();
        test_decode_err();
        test_stall();
        test_same_edge();
        test_back_to_back();
`ifdef AXIL_SLAVE_PROT_CHECK_EN
        test_prot();
`endif
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi4_lite_slave_regfile.md
# axi4_lite_slave_regfile

Parametrised AXI4-Lite slave with an internal register file. Successor to the fixed 32-bit pass-through slave: accepts AW and W in either order, applies WSTRB byte enables, decodes addresses against a configurable register count, and returns OKAY/SLVERR responses. Sits behind the AXI4-Lite master as the peripheral-side endpoint; register contents are exported flat for downstream logic.

## Interface
- DATA_W, 32, data width; 32 or 64 only
- ADDR_W, 12, address width
- NUM_REGS, 16, register count, 1..2^(ADDR_W-log2(DATA_W/8))

- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- awaddr_slave_input  in  ADDR_W  write address
- awprot_slave_input  in  3  write protection
- awvalid_slave_input  in  1  AW valid
- awready_slave_output  out  1  AW ready
- wdata_slave_input  in  DATA_W  write data
- wstrb_slave_input  in  DATA_W/8  byte strobes
- wvalid_slave_input  in  1  W valid
- wready_slave_output  out  1  W ready
- bresp_slave_output  out  2  write response
- bvalid_slave_output  out  1  B valid
- bready_slave_input  in  1  B ready
- araddr_slave_input  in  ADDR_W  read address
- arprot_slave_input  in  3  read protection
- arvalid_slave_input  in  1  AR valid
- arready_slave_output  out  1  AR ready
- rdata_slave_output  out  DATA_W  read data
- rresp_slave_output  out  2  read response
- rvalid_slave_output  out  1  R valid
- rready_slave_input  in  1  R ready
- regs_flat_output  out  NUM_REGS*DATA_W  register contents, reg i at bits [i*DATA_W +: DATA_W]

## Operation
- Word index = addr[ADDR_W-1 : log2(DATA_W/8)]; low byte-offset bits ignored. Index >= NUM_REGS → decode error.
- Write FSM states: WR_IDLE, WR_RESP.
  - WR_IDLE: awready = 1 while AW not yet captured; wready = 1 while W not yet captured. Each handshake latches its channel into a holding register; AW and W may arrive in either order or the same cycle.
  - When both held: commit; for each byte b with wstrb[b]=1 the register byte is updated; decode error → no update, bresp = 2'b10 (SLVERR), else 2'b00 (OKAY). Go to WR_RESP.
  - WR_RESP: bvalid = 1, awready = wready = 0; on bvalid && bready clear holding flags, return to WR_IDLE.
- Read FSM states: RD_IDLE, RD_DATA.
  - RD_IDLE: arready = 1; on arvalid && arready sample register into rdata (0 on decode error), rresp OKAY/SLVERR, go to RD_DATA.
  - RD_DATA: rvalid = 1, arready = 0; rdata/rresp stable until rvalid && rready, then RD_IDLE.
- Read and write paths independent; may be active concurrently.
- wstrb = 0 with valid address: OKAY, no register change.

## Timing
- Reset (reset = 0, asynchronous): all registers 0; awready, wready, arready, bvalid, rvalid = 0; bresp, rresp = 2'b00; rdata = 0; FSMs to idle, holding flags cleared. First cycle after release: awready, wready, arready = 1.
- Write latency: response bvalid rises the edge after the later of AW/W handshakes (both same cycle → bvalid next edge). Register visible on regs_flat_output at that same edge.
- Read latency: rvalid rises the edge after AR handshake.
- Read and write to same index committing on the same edge: read returns pre-write value.
- Back-to-back: new AW/W accepted the cycle after the B handshake; new AR the cycle after the R handshake (one idle ready cycle per transaction, no combinational ready→valid paths).
- valid deasserted while ready low: no effect; slave never drops bvalid/rvalid before handshake.
- reset asserted mid-transaction: transaction abandoned, no response issued, partial write not committed.

## Configuration
- AXIL_SLAVE_PROT_CHECK_EN defined: access with prot[0] = 0 (unprivileged) on AW or AR gets SLVERR; write not committed, read returns 0.
- Not defined: awprot/arprot ignored; only decode errors produce SLVERR.

## Test plan
- Reset then write 0xDEADBEEF to addr 0x004, wstrb 4'hF → bresp OKAY, reg 1 = 0xDEADBEEF; read 0x004 → rdata 0xDEADBEEF, rresp OKAY.
- W presented 3 cycles before AW, wstrb 4'b0101, data 0x11223344 onto reg holding 0xAAAAAAAA → reg = 0xAA22AA44, single bvalid.
- Write to addr 0x040 (index 16, NUM_REGS = 16) → bresp 2'b10, no register changes; read 0x040 → rdata 0, rresp 2'b10.
- bready held low 5 cycles → bvalid stays 1, awready/wready stay 0, bresp stable; rready stall likewise holds rdata.
- Write and read of reg 2 (old 0x5, new 0x9) committing same edge → rdata 0x5, subsequent read 0x9.
- With AXIL_SLAVE_PROT_CHECK_EN: write awprot 3'b000 → SLVERR, reg unchanged; awprot 3'b001 → OKAY. Reset asserted while bvalid high → bvalid 0 immediately.
